// File: rtl/sha_pkg.sv
// -----------------------------------------------------------------------------
// sha_pkg
// Shared types and helpers for the nonce sweep scheduler.
//   sweep_state_t     : scheduler FSM states
//   nonce_t           : 32-bit nonce
//   hash_word_t       : 32-bit hash word (word 0 of the SHA-256 digest)
//   SHA_BATCH_DEFAULT : default number of nonces per engine run
//   batch_is_last()   : true when the batch at 'base' reaches or passes 'last'
// -----------------------------------------------------------------------------
package sha_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_ADVANCE,
        S_FINISH
    } sweep_state_t;

    typedef logic [31:0] nonce_t;
    typedef logic [31:0] hash_word_t;

    localparam int SHA_BATCH_DEFAULT = 16;

    // Evaluated in 33 bits so a batch ending at or beyond 2^32-1 is seen as
    // the final one instead of wrapping the base back to zero.
    function automatic logic batch_is_last(nonce_t base, nonce_t last, int batch);
        logic [32:0] batch_top;
        batch_top = {1'b0, base} + 33'(batch) - 33'd1;
        return batch_top >= {1'b0, last};
    endfunction

endpackage

// File: rtl/sweep_result_tracker.sv
// -----------------------------------------------------------------------------
// sweep_result_tracker
// Filters per-nonce engine results to the configured range, compares each hash
// against the target and keeps the lowest qualifying nonce with its hash.
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   clear             drop any previous result (new sweep)
//   enable            results are accepted only while high
//   res_valid         one result word this cycle
//   res_idx           nonce offset within the current batch
//   res_hash          hash word 0 for that nonce
//   base, last        current batch base and inclusive range end
//   target            a hash qualifies when hash < target (unsigned)
//   found             at least one qualifying nonce seen
//   found_nonce       lowest qualifying nonce
//   found_hash        hash of found_nonce
// -----------------------------------------------------------------------------
module sweep_result_tracker
    import sha_pkg::*;
#(
    parameter int BATCH = SHA_BATCH_DEFAULT,
    parameter int IDX_W = $clog2(BATCH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             enable,
    input  logic             res_valid,
    input  logic [IDX_W-1:0] res_idx,
    input  logic [31:0]      res_hash,
    input  logic [31:0]      base,
    input  logic [31:0]      last,
    input  logic [31:0]      target,
    output logic             found,
    output logic [31:0]      found_nonce,
    output logic [31:0]      found_hash
);

    logic [32:0] nonce_wide;
    logic        in_range;
    logic        qualifies;
    logic        take;

    always_comb begin
        nonce_wide = {1'b0, base} + 33'(res_idx);
        // Entries past 'last' belong to the padding of a partial final batch.
        in_range   = (32'(res_idx) < 32'(BATCH)) && (nonce_wide <= {1'b0, last});
        qualifies  = res_hash < target;
        take       = enable && res_valid && in_range && qualifies &&
                     (!found || (nonce_wide[31:0] < found_nonce));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            found       <= 1'b0;
            found_nonce <= '0;
            found_hash  <= '0;
        end else if (clear) begin
            found       <= 1'b0;
            found_nonce <= '0;
            found_hash  <= '0;
        end else if (take) begin
            found       <= 1'b1;
            found_nonce <= nonce_wide[31:0];
            found_hash  <= res_hash;
        end
    end

endmodule

// File: rtl/nonce_sweep_scheduler.sv
// -----------------------------------------------------------------------------
// nonce_sweep_scheduler
// Drives one multi-instance SHA-256 engine across the nonce range [first,last]
// in batches of BATCH nonces and reports the lowest nonce whose hash word 0 is
// below the target.
// Ports:
//   clk, reset_n                   clock, asynchronous active-low reset
//   cfg_start                      start a sweep (honoured only when idle)
//   cfg_abort                      stop at the next batch boundary
//   cfg_nonce_first/last           inclusive nonce range
//   cfg_target                     qualifying threshold (hash < target)
//   eng_start                      one-cycle pulse launching a batch
//   eng_nonce_base                 base nonce of the running batch
//   eng_res_valid/idx/hash         per-nonce result from the engine
//   eng_done                       one-cycle pulse: batch complete
//   busy                           sweep in progress
//   done                           one-cycle pulse at sweep end
//   aborted                        last sweep ended by cfg_abort
//   found/found_nonce/found_hash   lowest qualifying result
//   batches_done                   completed batches (saturating)
// Build option:
//   NONCE_SWEEP_STOP_ON_FIND_EN    end the sweep after the first batch that
//                                  produced a qualifying nonce
// -----------------------------------------------------------------------------
module nonce_sweep_scheduler
    import sha_pkg::*;
#(
    parameter int BATCH = SHA_BATCH_DEFAULT,
    parameter int IDX_W = $clog2(BATCH),
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cfg_start,
    input  logic             cfg_abort,
    input  logic [31:0]      cfg_nonce_first,
    input  logic [31:0]      cfg_nonce_last,
    input  logic [31:0]      cfg_target,
    output logic             eng_start,
    output logic [31:0]      eng_nonce_base,
    input  logic             eng_res_valid,
    input  logic [IDX_W-1:0] eng_res_idx,
    input  logic [31:0]      eng_res_hash,
    input  logic             eng_done,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic             found,
    output logic [31:0]      found_nonce,
    output logic [31:0]      found_hash,
    output logic [CNT_W-1:0] batches_done
);

    sweep_state_t state;
    sweep_state_t state_next;

    nonce_t     base_q;
    nonce_t     last_q;
    hash_word_t target_q;
    logic       abort_pending;
    logic       aborted_q;
    logic [CNT_W-1:0] batches_q;

    logic load;
    logic step_base;
    logic finish_abort;

    // ---------------------------------------------------------------- FSM
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_next;
    end

    // NOTE: every signal gets a default at the top so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next   = state;
        load         = 1'b0;
        step_base    = 1'b0;
        finish_abort = 1'b0;
        eng_start    = 1'b0;
        done         = 1'b0;
        busy         = (state != S_IDLE);

        case (state)
            S_IDLE: begin
                if (cfg_start) begin
                    load       = 1'b1;
                    state_next = (cfg_nonce_first > cfg_nonce_last) ? S_FINISH : S_ISSUE;
                end
            end
            S_ISSUE: begin
                eng_start  = 1'b1;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                if (eng_done) state_next = S_ADVANCE;
            end
            S_ADVANCE: begin
                // Range exhaustion wins over abort: the sweep completed anyway.
                if (batch_is_last(base_q, last_q, BATCH)) begin
                    state_next = S_FINISH;
                end else if (abort_pending || cfg_abort) begin
                    state_next   = S_FINISH;
                    finish_abort = 1'b1;
`ifdef NONCE_SWEEP_STOP_ON_FIND_EN
                end else if (found) begin
                    // Batches ascend, so the first batch with a hit holds the
                    // lowest qualifying nonce of the whole range.
                    state_next = S_FINISH;
`endif
                end else begin
                    step_base  = 1'b1;
                    state_next = S_ISSUE;
                end
            end
            S_FINISH: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // --------------------------------------------------- sweep bookkeeping
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            base_q        <= '0;
            last_q        <= '0;
            target_q      <= '0;
            abort_pending <= 1'b0;
            aborted_q     <= 1'b0;
            batches_q     <= '0;
        end else begin
            if (load) begin
                base_q        <= cfg_nonce_first;
                last_q        <= cfg_nonce_last;
                target_q      <= cfg_target;
                abort_pending <= 1'b0;
                aborted_q     <= 1'b0;
                batches_q     <= '0;
            end else begin
                if (step_base) base_q <= base_q + nonce_t'(BATCH);

                // Abort is remembered until the batch boundary; it is only
                // sampled while a sweep is running.
                if (cfg_abort && (state inside {S_ISSUE, S_WAIT, S_ADVANCE}))
                    abort_pending <= 1'b1;

                if (finish_abort) aborted_q <= 1'b1;

                if (state == S_ADVANCE && batches_q != {CNT_W{1'b1}})
                    batches_q <= batches_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------ result tracking
    sweep_result_tracker #(
        .BATCH (BATCH),
        .IDX_W (IDX_W)
    ) u_tracker (
        .clk         (clk),
        .reset_n     (reset_n),
        .clear       (load),
        .enable      (state == S_WAIT),
        .res_valid   (eng_res_valid),
        .res_idx     (eng_res_idx),
        .res_hash    (eng_res_hash),
        .base        (base_q),
        .last        (last_q),
        .target      (target_q),
        .found       (found),
        .found_nonce (found_nonce),
        .found_hash  (found_hash)
    );

    assign eng_nonce_base = base_q;
    assign aborted        = aborted_q;
    assign batches_done   = batches_q;

endmodule

// File: tb/tb_nonce_sweep_scheduler.sv
// -----------------------------------------------------------------------------
// tb_nonce_sweep_scheduler
// Directed, table-driven bench for nonce_sweep_scheduler. A small engine model
// answers every eng_start with BATCH results (highest index first, the last
// one coinciding with eng_done) whose hashes come from a per-vector pattern.
// Expected results are hand-computed in the vector table.
// -----------------------------------------------------------------------------
module tb_nonce_sweep_scheduler;

    localparam int BATCH = 16;
    localparam int IDX_W = 4;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             cfg_start;
    logic             cfg_abort;
    logic [31:0]      cfg_nonce_first;
    logic [31:0]      cfg_nonce_last;
    logic [31:0]      cfg_target;
    logic             eng_start;
    logic [31:0]      eng_nonce_base;
    logic             eng_res_valid;
    logic [IDX_W-1:0] eng_res_idx;
    logic [31:0]      eng_res_hash;
    logic             eng_done;
    logic             busy;
    logic             done;
    logic             aborted;
    logic             found;
    logic [31:0]      found_nonce;
    logic [31:0]      found_hash;
    logic [CNT_W-1:0] batches_done;

    always #5 clk = ~clk;

    nonce_sweep_scheduler #(
        .BATCH (BATCH),
        .IDX_W (IDX_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .cfg_start       (cfg_start),
        .cfg_abort       (cfg_abort),
        .cfg_nonce_first (cfg_nonce_first),
        .cfg_nonce_last  (cfg_nonce_last),
        .cfg_target      (cfg_target),
        .eng_start       (eng_start),
        .eng_nonce_base  (eng_nonce_base),
        .eng_res_valid   (eng_res_valid),
        .eng_res_idx     (eng_res_idx),
        .eng_res_hash    (eng_res_hash),
        .eng_done        (eng_done),
        .busy            (busy),
        .done            (done),
        .aborted         (aborted),
        .found           (found),
        .found_nonce     (found_nonce),
        .found_hash      (found_hash),
        .batches_done    (batches_done)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] first;
        logic [31:0] last;
        logic [31:0] target;
        int          mode;          // hash pattern, see hash_of()
        int          abort_batch;   // batch during which cfg_abort pulses, -1 none
        int          restart_batch; // batch during which a stray cfg_start pulses, -1 none
        int          exp_starts;
        int          exp_batches;
        logic        exp_found;
        logic [31:0] exp_nonce;
        logic [31:0] exp_hash;
        logic        exp_aborted;
    } vec_t;

    // Hash word the engine model reports for a nonce.
    function automatic logic [31:0] hash_of(int mode, logic [31:0] n);
        logic [31:0] h;
        h = 32'hFFFF_FFFF;
        case (mode)
            1: begin if (n == 37) h = 32'd3;  else if (n == 21) h = 32'd7;  end
            2: h = 32'd0;
            3: begin if (n == 40) h = 32'd1;  else if (n == 35) h = 32'd2;  end
            4: begin if (n == 3)  h = 32'd100; else if (n == 9) h = 32'd99; end
            5: begin if (n == 20) h = 32'd0; end
            default: h = 32'hFFFF_FFFF;
        endcase
        return h;
    endfunction

    task automatic run_sweep(input vec_t v, input int vi);
        int          starts;
        int          cyc;
        bit          done_seen;
        logic [31:0] exp_base;

        // cfg_abort while idle must be ignored by the following sweep.
        @(negedge clk);
        cfg_abort = 1'b1;
        @(negedge clk);
        cfg_abort       = 1'b0;
        cfg_nonce_first = v.first;
        cfg_nonce_last  = v.last;
        cfg_target      = v.target;
        cfg_start       = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;

        starts    = 0;
        cyc       = 0;
        done_seen = 1'b0;
        while (!done_seen && cyc < 400) begin
            if (eng_start) begin
                exp_base = v.first + 32'(starts * BATCH);
                check($sformatf("v%0d_base%0d", vi, starts), eng_nonce_base, exp_base);
                @(negedge clk);
                check($sformatf("v%0d_start_pulse%0d", vi, starts), {31'd0, eng_start}, 32'd0);
                for (int k = BATCH - 1; k >= 0; k--) begin
                    eng_res_valid = 1'b1;
                    eng_res_idx   = IDX_W'(k);
                    eng_res_hash  = hash_of(v.mode, exp_base + 32'(k));
                    eng_done      = (k == 0);
                    cfg_abort     = (starts == v.abort_batch) && (k == 8);
                    if (starts == v.restart_batch && k == 4) begin
                        cfg_start      = 1'b1;
                        cfg_nonce_last = 32'd0;
                        cfg_target     = 32'd0;
                    end else begin
                        cfg_start      = 1'b0;
                        cfg_nonce_last = v.last;
                        cfg_target     = v.target;
                    end
                    if (k == 0)
                        check($sformatf("v%0d_base_hold%0d", vi, starts), eng_nonce_base, exp_base);
                    @(negedge clk);
                end
                eng_res_valid = 1'b0;
                eng_done      = 1'b0;
                cfg_abort     = 1'b0;
                cfg_start     = 1'b0;
                starts++;
                // eng_done -> next eng_start or done is two cycles.
                @(negedge clk);
                check($sformatf("v%0d_latency%0d", vi, starts), {31'd0, eng_start | done}, 32'd1);
                cyc += BATCH + 3;
            end else if (done) begin
                check($sformatf("v%0d_busy_at_done", vi), {31'd0, busy}, 32'd1);
                done_seen = 1'b1;
                @(negedge clk);
                check($sformatf("v%0d_done_pulse", vi), {31'd0, done}, 32'd0);
                check($sformatf("v%0d_busy_after", vi), {31'd0, busy}, 32'd0);
            end else begin
                @(negedge clk);
                cyc++;
            end
        end

        check($sformatf("v%0d_done_seen", vi), {31'd0, done_seen}, 32'd1);
        check($sformatf("v%0d_starts", vi), 32'(starts), 32'(v.exp_starts));
        check($sformatf("v%0d_batches", vi), 32'(batches_done), 32'(v.exp_batches));
        check($sformatf("v%0d_found", vi), {31'd0, found}, {31'd0, v.exp_found});
        check($sformatf("v%0d_found_nonce", vi), found_nonce, v.exp_nonce);
        check($sformatf("v%0d_found_hash", vi), found_hash, v.exp_hash);
        check($sformatf("v%0d_aborted", vi), {31'd0, aborted}, {31'd0, v.exp_aborted});
    endtask

    vec_t vecs[10];

    initial begin
        int stop_batches;
        int cyc;

`ifdef NONCE_SWEEP_STOP_ON_FIND_EN
        stop_batches = 2;
`else
        stop_batches = 10;
`endif
        //          first         last          target  mode abort rst starts batches found nonce         hash     ab
        vecs[0] = '{32'd0,        32'd31,       32'd0,   0,  -1,  -1,  2,     2,     1'b0, 32'd0,        32'd0,   1'b0};
        vecs[1] = '{32'd0,        32'd47,       32'd10,  1,  -1,  -1,  3,     3,     1'b1, 32'd21,       32'd7,   1'b0};
        vecs[2] = '{32'd10,       32'd12,       32'd1,   2,  -1,  -1,  1,     1,     1'b1, 32'd10,       32'd0,   1'b0};
        vecs[3] = '{32'hFFFFFFF0, 32'hFFFFFFFF, 32'd1,   2,  -1,  -1,  1,     1,     1'b1, 32'hFFFFFFF0, 32'd0,   1'b0};
        vecs[4] = '{32'd5,        32'd4,        32'd1,   2,  -1,  -1,  0,     0,     1'b0, 32'd0,        32'd0,   1'b0};
        vecs[5] = '{32'd0,        32'd159,      32'd0,   0,   0,  -1,  1,     1,     1'b0, 32'd0,        32'd0,   1'b1};
        vecs[6] = '{32'd32,       32'd47,       32'd10,  3,  -1,  -1,  1,     1,     1'b1, 32'd35,       32'd2,   1'b0};
        vecs[7] = '{32'd0,        32'd15,       32'd100, 4,  -1,   0,  1,     1,     1'b1, 32'd9,        32'd99,  1'b0};
        vecs[8] = '{32'd0,        32'd20,       32'd10,  1,  -1,  -1,  2,     2,     1'b0, 32'd0,        32'd0,   1'b0};
        vecs[9] = '{32'd0,        32'd159,      32'd1,   5,  -1,  -1,  stop_batches, stop_batches,
                    1'b1, 32'd20, 32'd0, 1'b0};

        reset_n         = 1'b0;
        cfg_start       = 1'b0;
        cfg_abort       = 1'b0;
        cfg_nonce_first = '0;
        cfg_nonce_last  = '0;
        cfg_target      = '0;
        eng_res_valid   = 1'b0;
        eng_res_idx     = '0;
        eng_res_hash    = '0;
        eng_done        = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_busy",    {31'd0, busy},      32'd0);
        check("rst_done",    {31'd0, done},      32'd0);
        check("rst_start",   {31'd0, eng_start}, 32'd0);
        check("rst_found",   {31'd0, found},     32'd0);
        check("rst_aborted", {31'd0, aborted},   32'd0);
        check("rst_batches", 32'(batches_done),  32'd0);
        check("rst_base",    eng_nonce_base,     32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) run_sweep(vecs[i], i);

        // Reset in the middle of a batch abandons the sweep completely.
        @(negedge clk);
        cfg_nonce_first = 32'd32;
        cfg_nonce_last  = 32'd159;
        cfg_target      = 32'd1;
        cfg_start       = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        cyc = 0;
        while (!eng_start && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("mid_start_seen", {31'd0, eng_start}, 32'd1);
        @(negedge clk);
        eng_res_valid = 1'b1;
        eng_res_idx   = '0;
        eng_res_hash  = 32'd0;
        @(negedge clk);
        eng_res_valid = 1'b0;
        check("mid_found",       {31'd0, found}, 32'd1);
        check("mid_found_nonce", found_nonce,    32'd32);
        reset_n = 1'b0;
        #1;
        check("mid_rst_busy",    {31'd0, busy},  32'd0);
        check("mid_rst_found",   {31'd0, found}, 32'd0);
        check("mid_rst_nonce",   found_nonce,    32'd0);
        check("mid_rst_hash",    found_hash,     32'd0);
        check("mid_rst_base",    eng_nonce_base, 32'd0);
        check("mid_rst_batches", 32'(batches_done), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Engine traffic while idle is ignored.
        for (int k = 0; k < 3; k++) begin
            eng_res_valid = 1'b1;
            eng_res_idx   = IDX_W'(k);
            eng_res_hash  = 32'd0;
            eng_done      = (k == 2);
            @(negedge clk);
        end
        eng_res_valid = 1'b0;
        eng_done      = 1'b0;
        @(negedge clk);
        check("idle_found",   {31'd0, found},     32'd0);
        check("idle_busy",    {31'd0, busy},      32'd0);
        check("idle_start",   {31'd0, eng_start}, 32'd0);
        check("idle_batches", 32'(batches_done),  32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
